// File: rtl/pipe_adder_pkg.sv
// Shared types and elaboration-time helpers for the pipelined adder/subtractor.
package pipe_adder_pkg;

    typedef enum logic {
        ADD_OP = 1'b0,
        SUB_OP = 1'b1
    } add_mode_e;

    // The pipeline slices the operands into equal chunks, so the width must divide evenly.
    function automatic bit width_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Valid/ready operand and result bus of the pipelined adder/subtractor.
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipe_adder_add_chunk.sv
// Combinational CHUNK-bit generate/propagate ripple adder; one instance per pipeline stage.
module add_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum   = p ^ c[CHUNK-1:0];
    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/pipe_adder.sv
// Pipelined carry-chain adder/subtractor: one CHUNK-bit ripple segment per stage,
// registered carry between stages, valid/ready handshake with full backpressure.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_adder_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
        $error("pipe_adder: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    add_mode_e mode;
    assign mode = add_mode_e'(bus.sub);

    logic             v_q   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             ovf_q [STAGES];

    logic             v_in  [STAGES];
    logic [WIDTH-1:0] a_in  [STAGES];
    logic [WIDTH-1:0] b_in  [STAGES];
    logic [WIDTH-1:0] s_in  [STAGES];
    logic             c_in  [STAGES];
    logic [WIDTH-1:0] s_nx  [STAGES];

    logic [CHUNK-1:0] ch_sum  [STAGES];
    logic             ch_cout [STAGES];
    logic             ch_msb  [STAGES];
    logic [STAGES-1:0] take;

    // Stage 0 takes the raw beat (b inverted, carry forced for SUB); later stages take the previous register.
    always_comb begin
        v_in[0] = bus.in_valid;
        a_in[0] = bus.a;
        b_in[0] = (mode == SUB_OP) ? ~bus.b : bus.b;
        c_in[0] = (mode == SUB_OP) ? 1'b1 : bus.cin;
        s_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k] = v_q[k-1];
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = c_q[k-1];
            s_in[k] = s_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        add_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a     (a_in[k][k*CHUNK +: CHUNK]),
            .b     (b_in[k][k*CHUNK +: CHUNK]),
            .cin   (c_in[k]),
            .sum   (ch_sum[k]),
            .cout  (ch_cout[k]),
            .c_msb (ch_msb[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_nx[k] = s_in[k];
            s_nx[k][k*CHUNK +: CHUNK] = ch_sum[k];
        end
    end

    // Ready chain from the output backwards: a stage may load if empty or if it drains this cycle.
    always_comb begin
        take       = '0;
        take[LAST] = ~v_q[LAST] | bus.out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            take[k] = ~v_q[k] | take[k+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                ovf_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (take[k]) begin
                    v_q[k] <= v_in[k];
                    if (v_in[k]) begin
                        a_q[k]   <= a_in[k];
                        b_q[k]   <= b_in[k];
                        s_q[k]   <= s_nx[k];
                        c_q[k]   <= ch_cout[k];
                        ovf_q[k] <= ch_msb[k] ^ ch_cout[k];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = take[0];
    assign bus.out_valid = v_q[LAST];
    assign bus.sum       = s_q[LAST];
    assign bus.cout      = c_q[LAST];
    assign bus.ovf       = ovf_q[LAST];
endmodule
